// File: rtl/pc_fetch_pkg.sv
// Shared state type and default widths for the PC fetch unit.
package pc_fetch_pkg;

    localparam int unsigned DEFAULT_PC_W     = 32;
    localparam int unsigned DEFAULT_INSTR_W  = 9;
    localparam int unsigned DEFAULT_OFF_W    = 7;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        StFetch,
        StWaitMem,
        StIssue,
        StResolve,
        StHalted
    } fetch_state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational next-PC candidates: sequential pc+1 and PC-relative branch target.
module branch_target_calc
    import pc_fetch_pkg::*;
#(
    parameter int unsigned PC_W  = DEFAULT_PC_W,
    parameter int unsigned OFF_W = DEFAULT_OFF_W
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    output logic [PC_W-1:0]  pc_inc,
    output logic [PC_W-1:0]  target
);

    logic [PC_W-1:0] offset_sext;

    // Target is relative to pc+1; all sums wrap modulo 2^PC_W.
    always_comb begin
        pc_inc      = pc + PC_W'(1);
        offset_sext = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
        target      = pc_inc + offset_sext;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch/issue/resolve sequencer for the 9-bit multicycle core.
// Optional branch statistics counters: define PC_FETCH_BRANCH_STATS_EN.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned     PC_W     = DEFAULT_PC_W,
    parameter int unsigned     INSTR_W  = DEFAULT_INSTR_W,
    parameter int unsigned     OFF_W    = DEFAULT_OFF_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_req,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               resolve_valid,
    input  logic               branch,
    input  logic               zero,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
`ifdef PC_FETCH_BRANCH_STATS_EN
    output logic [31:0]        taken_cnt,
    output logic [31:0]        retired_cnt,
`endif
    output logic               halted
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;
    logic            br_taken;

    branch_target_calc #(
        .PC_W  (PC_W),
        .OFF_W (OFF_W)
    ) u_branch_target_calc (
        .pc     (pc),
        .offset (instr[OFF_W-1:0]),
        .pc_inc (pc_inc),
        .target (br_target)
    );

    assign imem_addr = pc;
    assign br_taken  = branch & zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StFetch;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                StFetch: begin
                    imem_req <= 1'b1;
                    state    <= StWaitMem;
                end
                StWaitMem: begin
                    if (imem_valid) begin
                        instr       <= imem_data;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= StResolve;
                    end
                end
                StResolve: begin
                    // halt wins over a simultaneous taken branch.
                    if (resolve_valid) begin
                        if (halt) begin
                            halted <= 1'b1;
                            state  <= StHalted;
                        end else begin
                            pc    <= br_taken ? br_target : pc_inc;
                            state <= StFetch;
                        end
                    end
                end
                StHalted: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end
                default: state <= StFetch;
            endcase
        end
    end

`ifdef PC_FETCH_BRANCH_STATS_EN
    logic resolve_fire;

    assign resolve_fire = (state == StResolve) && resolve_valid && !halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt   <= '0;
            retired_cnt <= '0;
        end else if (resolve_fire) begin
            retired_cnt <= retired_cnt + 32'd1;
            if (br_taken) begin
                taken_cnt <= taken_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics not built; the branch outcome only steers the PC.
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed boundaries plus randomized handshakes.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        resolve_valid;
    logic        branch;
    logic        zero;
    logic        halt;
    logic [31:0] pc;
    logic        halted;
`ifdef PC_FETCH_BRANCH_STATS_EN
    logic [31:0] taken_cnt;
    logic [31:0] retired_cnt;
`endif

    pc_fetch_unit u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_valid    (imem_valid),
        .imem_data     (imem_data),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .resolve_valid (resolve_valid),
        .branch        (branch),
        .zero          (zero),
        .halt          (halt),
        .pc            (pc),
`ifdef PC_FETCH_BRANCH_STATS_EN
        .taken_cnt     (taken_cnt),
        .retired_cnt   (retired_cnt),
`endif
        .halted        (halted)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycle   = 0;
    logic [31:0] m_pc;
    logic [31:0] m_taken;
    logic [31:0] m_retired;
    int          req_cycle;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Inputs that must be ignored in the current phase get random values.
    task automatic junk_resolve();
        resolve_valid = 1'($urandom);
        branch        = 1'($urandom);
        zero          = 1'($urandom);
        halt          = 1'($urandom);
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_taken   = 32'h0;
        m_retired = 32'h0;
    endtask

    // Entered right after a negedge with the DUT in FETCH; returns likewise unless halted.
    task automatic do_instr(input logic [8:0] data, input int mem_dly, input int rdy_dly,
                            input int res_dly, input logic br, input logic z, input logic h);
        int off;
        @(negedge clk);
        check_eq("req_on", imem_req, 1'b1);
        check_eq("addr", imem_addr, m_pc);
        check_eq("ivld_idle", instr_valid, 1'b0);
        req_cycle = cycle;
        for (int i = 0; i < mem_dly; i++) begin
            imem_valid  = 1'b0;
            instr_ready = 1'($urandom);
            junk_resolve();
            @(negedge clk);
            check_eq("req_hold", imem_req, 1'b1);
            check_eq("addr_hold", imem_addr, m_pc);
        end
        imem_valid = 1'b1;
        imem_data  = data;
        junk_resolve();
        @(negedge clk);
        check_eq("ivld_set", instr_valid, 1'b1);
        check_eq("instr", instr, data);
        check_eq("req_drop", imem_req, 1'b0);
        imem_valid = 1'($urandom);
        imem_data  = 9'($urandom);
        for (int i = 0; i < rdy_dly; i++) begin
            instr_ready = 1'b0;
            junk_resolve();
            @(negedge clk);
            check_eq("ivld_hold", instr_valid, 1'b1);
            check_eq("instr_hold", instr, data);
            check_eq("pc_issue", pc, m_pc);
        end
        instr_ready = 1'b1;
        junk_resolve();
        @(negedge clk);
        check_eq("ivld_clr", instr_valid, 1'b0);
        instr_ready = 1'($urandom);
        for (int i = 0; i < res_dly; i++) begin
            junk_resolve();
            resolve_valid = 1'b0;
            imem_valid    = 1'($urandom);
            @(negedge clk);
            check_eq("pc_wait", pc, m_pc);
            check_eq("halted_wait", halted, 1'b0);
        end
        resolve_valid = 1'b1;
        branch        = br;
        zero          = z;
        halt          = h;
        @(negedge clk);
        if (!h) begin
            off = int'(data[6:0]);
            if (off >= 64) off -= 128;
            m_retired = m_retired + 1;
            if (br && z) begin
                m_pc    = m_pc + 32'(1 + off);
                m_taken = m_taken + 1;
            end else begin
                m_pc = m_pc + 1;
            end
        end
        check_eq("pc_next", pc, m_pc);
        check_eq("halted", halted, h);
`ifdef PC_FETCH_BRANCH_STATS_EN
        check_eq("taken_cnt", taken_cnt, m_taken);
        check_eq("retired_cnt", retired_cnt, m_retired);
`endif
        imem_valid  = 1'($urandom);
        instr_ready = 1'($urandom);
        junk_resolve();
    endtask

    task automatic fast(input logic [8:0] data, input logic br, input logic z);
        do_instr(data, 0, 0, 0, br, z, 1'b0);
    endtask

    initial begin
        int prev_req;
        rst_n         = 1'b0;
        imem_valid    = 1'b0;
        imem_data     = '0;
        instr_ready   = 1'b0;
        resolve_valid = 1'b0;
        branch        = 1'b0;
        zero          = 1'b0;
        halt          = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_ivld", instr_valid, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_halted", halted, 1'b0);
        rst_n = 1'b1;

        // Straight-line code at full rate: one request every 4 cycles.
        fast(9'h000, 1'b0, 1'b0);
        prev_req = req_cycle;
        for (int k = 0; k < 3; k++) begin
            fast(9'h000, 1'b0, 1'b0);
            check_eq("cpi4", 32'(req_cycle - prev_req), 32'd4);
            prev_req = req_cycle;
        end
        fast(9'h005, 1'b1, 1'b1);           // 4 -> 10
        fast(9'h07C, 1'b1, 1'b0);           // not taken: 10 -> 11
        check_eq("nt_pc11", pc, 32'd11);
        fast(9'h07E, 1'b1, 1'b1);           // 11 -> 10
        fast(9'h17C, 1'b1, 1'b1);           // 10 -> 7
        check_eq("tk_pc7", pc, 32'd7);
        fast(9'h07F, 1'b1, 1'b1);           // offset -1 loops on 7
        check_eq("loop_pc7", pc, 32'd7);
        fast(9'h078, 1'b1, 1'b1);           // 7 -> 0
        fast(9'h03F, 1'b1, 1'b1);           // 0 -> 64
        check_eq("max_fwd", pc, 32'd64);
        fast(9'h040, 1'b1, 1'b1);           // 64 -> 1
        fast(9'h07D, 1'b1, 1'b1);           // 1 -> FFFF_FFFF
        check_eq("neg_wrap", pc, 32'hFFFF_FFFF);
        fast(9'h1FF, 1'b0, 1'b1);           // pc+1 wraps to 0
        check_eq("inc_wrap", pc, 32'h0);
        do_instr(9'h0AA, 5, 3, 2, 1'b0, 1'b0, 1'b0);
        fast(9'h012, 1'b1, 1'b1);           // 1 -> 20
        do_instr(9'h07F, 1, 1, 1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            imem_valid  = 1'($urandom);
            imem_data   = 9'($urandom);
            instr_ready = 1'($urandom);
            junk_resolve();
            @(negedge clk);
            check_eq("halt_stay", halted, 1'b1);
            check_eq("halt_req", imem_req, 1'b0);
            check_eq("halt_ivld", instr_valid, 1'b0);
            check_eq("halt_pc", pc, 32'd20);
        end

        // Reset in the middle of a memory wait.
        rst_n = 1'b0;
        imem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        fast(9'h006, 1'b1, 1'b1);           // 0 -> 7
        @(negedge clk);
        check_eq("wait_addr7", imem_addr, 32'd7);
        imem_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_pc", pc, 32'h0);
        check_eq("arst_req", imem_req, 1'b0);
        @(negedge clk);
        rst_n      = 1'b1;
        imem_valid = 1'b1;                  // stray response, must be ignored
        imem_data  = 9'h155;
        model_reset();
        do_instr(9'h033, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        check_eq("restart_pc", pc, 32'd1);

        for (int n = 0; n < 150; n++) begin
            do_instr(9'($urandom), int'($urandom_range(4, 0)), int'($urandom_range(3, 0)),
                     int'($urandom_range(3, 0)), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
